// File: rtl/demux_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_router_if
//  Purpose  : Bundles the ingress handshake, the per-channel egress lanes and
//             the status outputs of demux_router. The slave modport is the
//             router's view; the master modport is the producer/consumer view.
//  Revision : 1.0 - initial release
// ============================================================================
interface demux_router_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
);
    // Ingress side: one payload plus its destination channel per transfer.
    logic [DATA_W-1:0]       in;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;

    // Egress side: channel k occupies out[k*DATA_W +: DATA_W].
    logic [N_OUT*DATA_W-1:0] out;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;

    // Status.
    logic [15:0]             drop_cnt;
    logic                    busy;

    modport slave (
        input  in,
        input  sel,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready,
        output drop_cnt,
        output busy
    );

    modport master (
        output in,
        output sel,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready,
        input  drop_cnt,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : demux_router
//  Purpose  : Single-entry demultiplexer. Each accepted payload is parked in a
//             holding register and presented on exactly one output channel one
//             cycle later. Out-of-range destinations are swallowed and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_router_if.slave   bus
);

    // Two-state occupancy FSM for the holding register.
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_chan;
    logic [15:0]       r_drop_cnt;

    logic w_held_ready;
    logic w_in_ready;
    logic w_in_xfer;
    logic w_sel_ok;
    logic w_load;
    logic w_drop;
    logic w_drain;

    // Ready of the consumer currently addressed by the holding register.
    // A compare loop keeps the lookup well-defined when 2**SEL_W > N_OUT.
    always_comb begin
        w_held_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_chan == SEL_W'(k)) begin
                w_held_ready = bus.out_ready[k];
            end
        end
    end

    // Accept when empty, or when the held entry leaves this same cycle so the
    // register can be refilled without a bubble. Independent of in_valid/sel.
    assign w_in_ready = (r_state == c_EMPTY) || w_held_ready;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_sel_ok   = (32'(bus.sel) < N_OUT);
    assign w_load     = w_in_xfer && w_sel_ok;
    assign w_drop     = w_in_xfer && !w_sel_ok;
    assign w_drain    = (r_state == c_FULL) && w_held_ready;

    // Next-state: a valid load always wins; otherwise a drain empties the
    // register (a simultaneous drop does not refill it).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: begin
                if (w_load) begin
                    w_state_nxt = c_FULL;
                end
            end
            c_FULL: begin
                if (w_load) begin
                    w_state_nxt = c_FULL;
                end else if (w_drain) begin
                    w_state_nxt = c_EMPTY;
                end
            end
            default: begin
                w_state_nxt = c_EMPTY;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register: only a routable payload overwrites it; it is frozen
    // while the addressed consumer stalls because in_ready is then low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_chan <= '0;
        end else if (w_load) begin
            r_data <= bus.in;
            r_chan <= bus.sel;
        end
    end

    // Saturating counter of discarded out-of-range transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Per-channel output lanes: only the held channel carries data and valid,
    // every other lane (and all lanes while empty) is forced to zero.
    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_lane
            logic w_lane_hit;
            assign w_lane_hit                   = (r_state == c_FULL) && (r_chan == SEL_W'(k));
            assign bus.out_valid[k]             = w_lane_hit;
            assign bus.out[k*DATA_W +: DATA_W]  = w_lane_hit ? r_data : '0;
        end
    endgenerate

    assign bus.in_ready = w_in_ready;
    assign bus.drop_cnt = r_drop_cnt;
    assign bus.busy     = (r_state == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_router
//  Purpose  : Self-checking bench for demux_router. Two instances: the default
//             8-channel build and a 6-channel build with 3-bit select for the
//             out-of-range and saturation behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_router;

    typedef struct {
        int         chan;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    int   n_cmp;
    int   n_err;
    int   exp_drop6;
    exp_t q8[$];
    exp_t q6[$];

    demux_router_if #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) b8 ();
    demux_router_if #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) b6 ();

    demux_router #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    demux_router #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one payload that the bench expects to be accepted on the next edge.
    task automatic send(input int which, input int s, input logic [7:0] d);
        if (which == 0) begin
            b8.in = d; b8.sel = 3'(s); b8.in_valid = 1'b1;
        end else begin
            b6.in = d; b6.sel = 3'(s); b6.in_valid = 1'b1;
        end
        #1;
        if (which == 0) begin
            check_val("in_ready8", b8.in_ready, 1);
            q8.push_back('{s, d});
        end else begin
            check_val("in_ready6", b6.in_ready, 1);
            if (s < 6) q6.push_back('{s, d});
            else if (exp_drop6 < 'hFFFF) exp_drop6++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        b8.in_valid = 1'b0;
        b6.in_valid = 1'b0;
    endtask

    // Scoreboard: when an output transfer is about to happen, pop and compare.
    always @(negedge clk) begin
        if ((b8.out_valid & b8.out_ready) != 0) begin
            if (q8.size() == 0) begin
                check_val("sb8_unexpected", 64'(b8.out_valid), 0);
            end else begin
                exp_t e;
                logic [63:0] v;
                e = q8.pop_front();
                v = '0;
                v[e.chan*8 +: 8] = e.data;
                check_val("sb8_valid", 64'(b8.out_valid), 64'(1) << e.chan);
                check_val("sb8_out", b8.out, v);
            end
        end
        if ((b6.out_valid & b6.out_ready) != 0) begin
            if (q6.size() == 0) begin
                check_val("sb6_unexpected", 64'(b6.out_valid), 0);
            end else begin
                exp_t e;
                logic [47:0] v;
                e = q6.pop_front();
                v = '0;
                v[e.chan*8 +: 8] = e.data;
                check_val("sb6_valid", 64'(b6.out_valid), 64'(1) << e.chan);
                check_val("sb6_out", 64'(b6.out), 64'(v));
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; exp_drop6 = 0;
        rst_n = 1'b0;
        b8.in = '0; b8.sel = '0; b8.in_valid = 1'b0; b8.out_ready = 8'hFF;
        b6.in = '0; b6.sel = '0; b6.in_valid = 1'b0; b6.out_ready = 6'h3F;

        // Reset state.
        #1;
        check_val("rst_valid8", 64'(b8.out_valid), 0);
        check_val("rst_out8", b8.out, 0);
        check_val("rst_drop8", 64'(b8.drop_cnt), 0);
        check_val("rst_busy8", 64'(b8.busy), 0);
        check_val("rst_ready8", 64'(b8.in_ready), 1);
        check_val("rst_drop6", 64'(b6.drop_cnt), 0);

        // Defaults: release between edges, first edge accepts A5 to channel 3.
        #21;
        rst_n = 1'b1;
        send(0, 3, 8'hA5);
        idle();
        check_val("def_valid", 64'(b8.out_valid), 64'h08);
        check_val("def_out", b8.out, 64'hA5 << 24);
        @(posedge clk); #1;
        check_val("def_empty", 64'(b8.busy), 0);

        // Backpressure on channel 5.
        b8.out_ready = 8'hDF;
        send(0, 5, 8'h3C);
        idle();
        for (int i = 0; i < 4; i++) begin
            check_val("bp_in_ready", 64'(b8.in_ready), 0);
            check_val("bp_busy", 64'(b8.busy), 1);
            check_val("bp_out", b8.out, 64'h3C << 40);
            check_val("bp_valid", 64'(b8.out_valid), 64'h20);
            @(posedge clk); #1;
        end
        b8.out_ready = 8'hFF;
        @(posedge clk); #1;
        check_val("bp_empty", 64'(b8.busy), 0);
        check_val("bp_valid0", 64'(b8.out_valid), 0);

        // Streaming sweep 0..7 back-to-back: one-hot valid walks every cycle.
        for (int i = 0; i < 8; i++) begin
            send(0, i, 8'(8'h10 + i));
            check_val("st_onehot", 64'(b8.out_valid), 64'(1) << i);
        end
        idle();
        @(posedge clk); #1;
        check_val("st_empty", 64'(b8.busy), 0);

        // Drops on the 6-channel build, then normal delivery.
        send(1, 6, 8'h11);
        send(1, 7, 8'h22);
        idle();
        check_val("drop_cnt2", 64'(b6.drop_cnt), 64'(exp_drop6));
        check_val("drop_valid0", 64'(b6.out_valid), 0);
        check_val("drop_busy0", 64'(b6.busy), 0);
        send(1, 2, 8'h5A);
        idle();
        check_val("drop_deliver", 64'(b6.out_valid), 64'h04);
        // A drop coinciding with a drain leaves the router empty.
        @(posedge clk); #1;
        send(1, 4, 8'h77);
        send(1, 7, 8'h99);
        idle();
        check_val("drop_drain_busy", 64'(b6.busy), 0);
        check_val("drop_cnt3", 64'(b6.drop_cnt), 64'(exp_drop6));

        // Reset mid-operation: channel 1 held under backpressure.
        b8.out_ready = 8'hFD;
        send(0, 1, 8'hC3);
        idle();
        check_val("mr_busy", 64'(b8.busy), 1);
        #2;
        rst_n = 1'b0;
        q8.delete(); q6.delete(); exp_drop6 = 0;
        #1;
        check_val("mr_valid", 64'(b8.out_valid), 0);
        check_val("mr_out", b8.out, 0);
        check_val("mr_drop", 64'(b8.drop_cnt), 0);
        check_val("mr_ready", 64'(b8.in_ready), 1);
        check_val("mr_drop6", 64'(b6.drop_cnt), 0);
        rst_n = 1'b1;
        b8.out_ready = 8'hFF;
        @(posedge clk); #1;
        check_val("mr_idle", 64'(b8.busy), 0);

        // Saturation: 65540 consecutive drops.
        b6.in = 8'hEE; b6.sel = 3'd7; b6.in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (exp_drop6 < 'hFFFF) exp_drop6++;
        end
        #1;
        check_val("sat_cnt", 64'(b6.drop_cnt), 64'(exp_drop6));
        check_val("sat_ready", 64'(b6.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        idle();
        check_val("sat_hold", 64'(b6.drop_cnt), 64'h0000_FFFF);
        check_val("sat_valid0", 64'(b6.out_valid), 0);

        @(posedge clk); #1;
        check_val("sb8_drained", 64'(q8.size()), 0);
        check_val("sb6_drained", 64'(q6.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
